vscale_csr_host_bridge: RTL
===========================

VSCALE_CSR_HOST_BRIDGE -- requirements
Module: vscale_csr_host_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles a request waits for the CSR port before an error response.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have host request ports:
- host_req_valid  input  1  request present
- host_req_ready  output  1  request accepted this cycle
- host_req_addr  input  CSR_ADDR_WIDTH (12)  target CSR
- host_req_cmd  input  CSR_CMD_WIDTH (3)  CSR_READ/WRITE/SET/CLEAR encoding
- host_req_wdata  input  XPR_LEN (32)  write operand
REQ-005 SHALL have host response ports:
- host_resp_valid  output  1  response present
- host_resp_ready  input  1  host takes response
- host_resp_rdata  output  32  CSR value before the access
- host_resp_error  output  1  access failed
REQ-006 SHALL have CSR-file initiator ports:
- csr_busy  input  1  pipeline owns CSR port this cycle
- csr_req  output  1
- csr_addr  output  12
- csr_cmd  output  3
- csr_wdata  output  32
- csr_rdata  input  32  combinational read of csr_addr
- csr_illegal_access  input  1

Function
REQ-007 SHALL implement states IDLE, WAIT, RESP.
REQ-008 IDLE: host_req_ready=1; on host_req_valid SHALL latch addr/cmd/wdata and go to WAIT, or directly to RESP with error=1, rdata=0 if the request is locally rejected (REQ-009).
REQ-009 Local reject SHALL occur when cmd[2]=0, or when cmd is WRITE/SET/CLEAR and addr[11:10]=2'b11; no csr_req is issued.
REQ-010 WAIT, csr_busy=0: SHALL assert csr_req=1 for exactly that cycle with the latched addr/cmd/wdata; SHALL capture csr_rdata and csr_illegal_access into host_resp_rdata/host_resp_error in the same cycle; next state RESP.
REQ-011 WAIT, csr_busy=1: SHALL increment an 8-bit wait counter; when the counter equals TIMEOUT_CYCLES SHALL go to RESP with error=1, rdata=0, no csr_req.
REQ-012 csr_busy=1 in a cycle SHALL always suppress csr_req, including the cycle the counter reaches its limit.
REQ-013 RESP: host_resp_valid=1 with stable rdata/error until host_resp_ready=1; then IDLE. host_req_ready=0 in WAIT and RESP.
REQ-014 Wait counter SHALL clear on entry to WAIT; minimum accept-to-response latency is 2 cycles (accept, issue, valid on the following cycle).
REQ-015 For SET/CLEAR/WRITE, rdata SHALL be the pre-write value.
REQ-016 csr_req SHALL be 0 outside WAIT; csr_addr/csr_cmd/csr_wdata SHALL present latched values at all times; csr_cmd SHALL be CSR_IDLE when csr_req=0.
REQ-017 At most one request SHALL be outstanding; no buffering beyond the single latched request.

Reset
REQ-018 reset_n=0 SHALL asynchronously force IDLE, csr_req=0, host_resp_valid=0, host_resp_rdata=0, host_resp_error=0, counter=0, latched fields=0.
REQ-019 Reset mid-WAIT or mid-RESP SHALL drop the request with no response and no csr_req.

Structure
REQ-020 CSR_CMD encodings, CSR_ADDR_WIDTH, XPR_LEN SHALL come from the shared ctrl-constants/opcodes headers; state encodings are local.
REQ-021 SHALL be a single module with no sub-modules.

Verification
REQ-022 Read mstatus (0x300), csr_busy=0, csr_rdata=0x00001800 -> one csr_req cycle with cmd=READ, response rdata=0x00001800, error=0, resp_valid 2 cycles after accept.
REQ-023 Write 0x342 (mcause) with csr_busy=1 for 5 cycles -> csr_req asserted exactly once, in cycle 6 of WAIT; error=0.
REQ-024 WRITE to 0xF14 (mhartid) -> no csr_req, resp error=1, rdata=0.
REQ-025 TIMEOUT_CYCLES=4, csr_busy held 1 -> error response after 4 wait cycles, csr_req never asserted.
REQ-026 Read undefined 0x7FF, csr_illegal_access=1 -> error=1; resp held 3 cycles with host_resp_ready=0, values stable, then IDLE.
REQ-027 reset_n low during WAIT -> all outputs 0 immediately, next request served normally.

Source files
------------

// File: rtl/vscale_csr_host_bridge_pkg.sv
// Shared CSR command encodings, widths and request record for the host-to-CSR bridge.
// Mirrors the vscale ctrl-constants / opcodes definitions so the bridge stays in step with the core.
package vscale_csr_host_bridge_pkg;

    localparam int CSR_ADDR_WIDTH = 12;
    localparam int CSR_CMD_WIDTH  = 3;
    localparam int XPR_LEN        = 32;

    localparam logic [CSR_CMD_WIDTH-1:0] CSR_IDLE  = 3'd0;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_READ  = 3'd4;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_WRITE = 3'd5;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_SET   = 3'd6;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_CLEAR = 3'd7;

    typedef struct packed {
        logic [CSR_ADDR_WIDTH-1:0] addr;
        logic [CSR_CMD_WIDTH-1:0]  cmd;
        logic [XPR_LEN-1:0]        wdata;
    } csr_host_req_t;

    // Non-access commands, and any modification of the read-only CSR space (addr[11:10]==2'b11),
    // are refused without touching the CSR file.
    function automatic logic csr_local_reject(input logic [CSR_ADDR_WIDTH-1:0] addr,
                                              input logic [CSR_CMD_WIDTH-1:0]  cmd);
        return !cmd[2] || ((cmd != CSR_READ) && (addr[11:10] == 2'b11));
    endfunction

endpackage

// File: rtl/vscale_csr_host_bridge.sv
// Bridges single host CSR requests onto the pipeline's shared CSR port, yielding whenever the
// pipeline owns it and giving up with an error response after TIMEOUT_CYCLES busy cycles.
module vscale_csr_host_bridge
    import vscale_csr_host_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      host_req_valid,
    output logic                      host_req_ready,
    input  logic [CSR_ADDR_WIDTH-1:0] host_req_addr,
    input  logic [CSR_CMD_WIDTH-1:0]  host_req_cmd,
    input  logic [XPR_LEN-1:0]        host_req_wdata,
    output logic                      host_resp_valid,
    input  logic                      host_resp_ready,
    output logic [XPR_LEN-1:0]        host_resp_rdata,
    output logic                      host_resp_error,
    input  logic                      csr_busy,
    output logic                      csr_req,
    output logic [CSR_ADDR_WIDTH-1:0] csr_addr,
    output logic [CSR_CMD_WIDTH-1:0]  csr_cmd,
    output logic [XPR_LEN-1:0]        csr_wdata,
    input  logic [XPR_LEN-1:0]        csr_rdata,
    input  logic                      csr_illegal_access,
    output logic [1:0]                state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // host_req_ready is high only in IDLE; host_resp_valid is high only in RESP and the
    // response fields are held stable until host_resp_ready is seen.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_e        state_q, state_d;
    csr_host_req_t req_q, req_d;
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic [7:0]    wait_cnt_inc;
    logic [XPR_LEN-1:0] rdata_q, rdata_d;
    logic          error_q, error_d;

    assign wait_cnt_inc = wait_cnt_q + 8'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            wait_cnt_q <= '0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            wait_cnt_q <= wait_cnt_d;
            rdata_q    <= rdata_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        wait_cnt_d      = wait_cnt_q;
        rdata_d         = rdata_q;
        error_d         = error_q;
        host_req_ready  = 1'b0;
        host_resp_valid = 1'b0;
        csr_req         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                host_req_ready = 1'b1;
                if (host_req_valid) begin
                    req_d.addr  = host_req_addr;
                    req_d.cmd   = host_req_cmd;
                    req_d.wdata = host_req_wdata;
                    wait_cnt_d  = '0;
                    if (csr_local_reject(host_req_addr, host_req_cmd)) begin
                        rdata_d = '0;
                        error_d = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // The CSR file reads combinationally, so the pre-access value is captured
                // in the same cycle the access is issued.
                if (!csr_busy) begin
                    csr_req = 1'b1;
                    rdata_d = csr_rdata;
                    error_d = csr_illegal_access;
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                    if (wait_cnt_inc == TIMEOUT_LIMIT) begin
                        rdata_d = '0;
                        error_d = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                host_resp_valid = 1'b1;
                if (host_resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign csr_addr        = req_q.addr;
    assign csr_wdata       = req_q.wdata;
    assign csr_cmd         = csr_req ? req_q.cmd : CSR_IDLE;
    assign host_resp_rdata = rdata_q;
    assign host_resp_error = error_q;
    assign state_dbg       = state_q;

endmodule
